// File: rtl/sdram_cmd_queue.sv
// Host command FIFO and one-at-a-time sequencer in front of the single-access SDRAM controller.
// Each popped command is driven as a level request until done/timeout, then answered with one response pulse.
module sdram_cmd_queue #(
    parameter int DEPTH   = 8,
    parameter int AW      = 23,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [AW-1:0]            cmd_addr,
    input  logic [DW-1:0]            cmd_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_we,
    output logic [DW-1:0]            rsp_rdata,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [AW-1:0]            ctl_addrin,
    output logic                     ctl_wrreq,
    output logic                     ctl_rereq,
    output logic [DW-1:0]            ctl_datain,
    input  logic [DW-1:0]            ctl_dataout,
    input  logic                     ctl_done,
    input  logic                     ctl_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + AW + DW;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [15:0]   TIMEOUT_VAL = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;

    logic [EW-1:0]   fifo_mem_r [DEPTH];
    logic [EW-1:0]   head_s;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic [15:0]     timer_r;
    logic            done_prev_r;
    logic            hold_we_r;
    logic [DW-1:0]   cap_rdata_r;
    logic            cap_err_r;

    logic            push_s;
    logic            pop_s;
    logic            capture_s;
    logic            abort_s;
    logic            respond_s;
    logic            timeout_s;
    logic            done_rise_s;

    assign cmd_ready   = ~rst & (count_r != FULL_COUNT);
    assign push_s      = cmd_valid & cmd_ready;
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign timeout_s   = (timer_r == TIMEOUT_VAL);
    assign done_rise_s = ctl_done & ~done_prev_r;
    assign q_count     = count_r;

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_we, cmd_addr, cmd_wdata};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-cycle action strobes
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        capture_s    = 1'b0;
        abort_s      = 1'b0;
        respond_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // busy must be low so the controller cannot latch a stale request
                if ((count_r != {CW{1'b0}}) && !ctl_busy) begin
                    pop_s        = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (timeout_s) begin
                    abort_s      = 1'b1;
                    state_next_s = RELEASE;
                end else if (ctl_busy) begin
                    state_next_s = WAIT_DONE;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            WAIT_DONE: begin
                if (done_rise_s) begin
                    capture_s    = 1'b1;
                    state_next_s = RELEASE;
                end else if (timeout_s) begin
                    abort_s      = 1'b1;
                    state_next_s = RELEASE;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            RELEASE: begin
                if (!ctl_busy) begin
                    respond_s    = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RELEASE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Pointers, occupancy, timer, controller request and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            timer_r     <= 16'd0;
            done_prev_r <= 1'b0;
            hold_we_r   <= 1'b0;
            cap_rdata_r <= {DW{1'b0}};
            cap_err_r   <= 1'b0;
            ctl_addrin  <= {AW{1'b0}};
            ctl_datain  <= {DW{1'b0}};
            ctl_wrreq   <= 1'b0;
            ctl_rereq   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_we      <= 1'b0;
            rsp_rdata   <= {DW{1'b0}};
            rsp_err     <= 1'b0;
        end else begin
            done_prev_r <= ctl_done;

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase

            // timer spans both ISSUE and WAIT_DONE so a controller that never goes busy also aborts
            if (pop_s) begin
                timer_r <= 16'd0;
            end else if ((state_r == ISSUE) || (state_r == WAIT_DONE)) begin
                timer_r <= timer_r + 16'd1;
            end

            if (pop_s) begin
                hold_we_r  <= head_s[EW-1];
                ctl_addrin <= head_s[AW+DW-1:DW];
                ctl_datain <= head_s[DW-1:0];
                ctl_wrreq  <= head_s[EW-1];
                ctl_rereq  <= ~head_s[EW-1];
            end else if (capture_s || abort_s) begin
                ctl_wrreq  <= 1'b0;
                ctl_rereq  <= 1'b0;
            end

            if (capture_s) begin
                cap_rdata_r <= hold_we_r ? {DW{1'b0}} : ctl_dataout;
                cap_err_r   <= 1'b0;
            end else if (abort_s) begin
                cap_rdata_r <= {DW{1'b0}};
                cap_err_r   <= 1'b1;
            end

            rsp_valid <= respond_s;
            if (respond_s) begin
                rsp_we    <= hold_we_r;
                rsp_rdata <= cap_rdata_r;
                rsp_err   <= cap_err_r;
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// Scoreboard bench for sdram_cmd_queue with a small behavioural SDRAM controller model.
module tb_sdram_cmd_queue;

    localparam int AW    = 23;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic            rsp_valid;
    logic            rsp_we;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [3:0]      q_count;
    logic [AW-1:0]   ctl_addrin;
    logic            ctl_wrreq;
    logic            ctl_rereq;
    logic [DW-1:0]   ctl_datain;
    logic [DW-1:0]   ctl_dataout;
    logic            ctl_done;
    logic            ctl_busy;

    always #5 clk = ~clk;

    sdram_cmd_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .q_count(q_count),
        .ctl_addrin(ctl_addrin), .ctl_wrreq(ctl_wrreq), .ctl_rereq(ctl_rereq),
        .ctl_datain(ctl_datain), .ctl_dataout(ctl_dataout),
        .ctl_done(ctl_done), .ctl_busy(ctl_busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    rsp_t exp_rsp[$];
    req_t exp_req[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Controller model: busy on request, done pulse after a short access, busy until request drops
    logic            busy_m = 1'b0;
    logic            done_m = 1'b0;
    logic [DW-1:0]   dout_m = '0;
    logic            stall = 1'b0;
    logic            no_done = 1'b0;
    int              ph = 0;
    int              cnt = 0;
    logic            m_we = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_data = '0;
    logic [DW-1:0]   mem_m [4096];

    assign ctl_busy    = busy_m | stall;
    assign ctl_done    = done_m;
    assign ctl_dataout = dout_m;

    always @(posedge clk) begin
        if (rst) begin
            busy_m <= 1'b0;
            done_m <= 1'b0;
            ph     <= 0;
        end else begin
            case (ph)
                0: if ((ctl_wrreq | ctl_rereq) && !stall) begin
                    busy_m <= 1'b1;
                    cnt    <= 3;
                    ph     <= 1;
                    m_we   <= ctl_wrreq;
                    m_addr <= ctl_addrin;
                    m_data <= ctl_datain;
                end
                1: if (!(ctl_wrreq | ctl_rereq)) begin
                    busy_m <= 1'b0;
                    ph     <= 0;
                end else if (cnt > 0) begin
                    cnt <= cnt - 1;
                end else if (!no_done) begin
                    done_m <= 1'b1;
                    ph     <= 2;
                    if (m_we) mem_m[m_addr[11:0]] <= m_data;
                    else      dout_m <= mem_m[m_addr[11:0]];
                end
                2: begin
                    done_m <= 1'b0;
                    if (!(ctl_wrreq | ctl_rereq)) begin
                        busy_m <= 1'b0;
                        ph     <= 0;
                    end
                end
                default: ph <= 0;
            endcase
        end
    end

    // Response monitor
    logic rsp_prev = 1'b0;
    always @(negedge clk) begin : rsp_mon
        rsp_t e;
        if (rsp_valid) begin
            check("rsp_single_cycle", {31'd0, rsp_prev}, 32'd0);
            if (exp_rsp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=we%0b/%0h/err%0b required=none", rsp_we, rsp_rdata, rsp_err);
            end else begin
                e = exp_rsp.pop_front();
                check("rsp_we", {31'd0, rsp_we}, {31'd0, e.we});
                check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
        rsp_prev = rsp_valid;
    end

    // Request monitor: order, contents, stability, exclusivity
    logic req_prev = 1'b0;
    req_t cur_req = '0;
    always @(negedge clk) begin : req_mon
        logic req_now;
        req_now = ctl_wrreq | ctl_rereq;
        if (ctl_wrreq && ctl_rereq) begin
            checks++;
            errors++;
            $display("FAIL req_both actual=wr1/re1 required=one");
        end
        if (req_now && !req_prev) begin
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req actual=addr %0h required=none", ctl_addrin);
            end else begin
                cur_req = exp_req.pop_front();
                check("req_we", {31'd0, ctl_wrreq}, {31'd0, cur_req.we});
                check("req_addr", {9'd0, ctl_addrin}, {9'd0, cur_req.addr});
                check("req_data", {16'd0, ctl_datain}, {16'd0, cur_req.data});
                check("req_busy_clear", {31'd0, ctl_busy}, 32'd0);
            end
        end else if (req_now && req_prev) begin
            check("req_hold_addr", {9'd0, ctl_addrin}, {9'd0, cur_req.addr});
            check("req_hold_kind", {31'd0, ctl_wrreq}, {31'd0, cur_req.we});
        end
        req_prev = req_now;
    end

    task automatic drive_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] er, input logic ee);
        int guard;
        guard     = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout actual=not_ready required=accepted addr %0h", a);
            cmd_valid = 1'b0;
            return;
        end
        exp_req.push_back('{we, a, d});
        exp_rsp.push_back('{we, er, ee});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] er, input logic ee);
        @(negedge clk);
        drive_cmd(we, a, d, er, ee);
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (exp_rsp.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_rsp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain actual=%0d pending required=0", name, exp_rsp.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int guard;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        repeat (3) @(negedge clk);

        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_wrreq", {31'd0, ctl_wrreq}, 32'd0);
        check("rst_rereq", {31'd0, ctl_rereq}, 32'd0);
        check("rst_q_count", {28'd0, q_count}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // single write
        send(1'b1, 23'h12345, 16'hBEEF, 16'h0, 1'b0);
        drain("t1");

        // write then read back
        send(1'b1, 23'h00010, 16'hA5A5, 16'h0, 1'b0);
        send(1'b0, 23'h00010, 16'h0, 16'hA5A5, 1'b0);
        drain("t2");

        // fill while controller stalls busy
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 23'h200 + 23'(i), 16'h3000 + 16'(i), 16'h0, 1'b0);
        end
        @(negedge clk);
        check("full_q_count", {28'd0, q_count}, 32'd8);
        check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        stall = 1'b0;
        send(1'b0, 23'h203, 16'h0, 16'h3003, 1'b0);
        drain("t3");
        repeat (5) @(negedge clk);
        check("rsp_rdata_hold", {16'd0, rsp_rdata}, 32'h3003);

        // timeout abort, then normal traffic resumes
        no_done = 1'b1;
        send(1'b0, 23'h00099, 16'h0, 16'h0, 1'b1);
        n = 0;
        guard = 0;
        while (exp_rsp.size() != 0 && guard < 3000) begin
            @(negedge clk);
            if (ctl_rereq) n++;
            guard++;
        end
        check("timeout_req_cycles_in_range", {31'd0, (n >= 16 && n <= 18)}, 32'd1);
        no_done = 1'b0;
        drain("t4");
        send(1'b1, 23'h00055, 16'h1234, 16'h0, 1'b0);
        send(1'b0, 23'h00055, 16'h0, 16'h1234, 1'b0);
        drain("t4b");

        // reset during WAIT_DONE discards everything
        no_done = 1'b1;
        send(1'b1, 23'h00077, 16'h7777, 16'h0, 1'b0);
        send(1'b0, 23'h00078, 16'h0, 16'h0, 1'b0);
        guard = 0;
        while (!ctl_wrreq && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("t5_req_seen", {31'd0, ctl_wrreq}, 32'd1);
        repeat (5) @(negedge clk);
        check("t5_pre_rst_q_count", {28'd0, q_count}, 32'd1);
        rst = 1'b1;
        exp_rsp.delete();
        exp_req.delete();
        @(negedge clk);
        check("t5_wrreq", {31'd0, ctl_wrreq}, 32'd0);
        check("t5_rereq", {31'd0, ctl_rereq}, 32'd0);
        check("t5_q_count", {28'd0, q_count}, 32'd0);
        check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        no_done = 1'b0;
        repeat (20) @(negedge clk);

        // simultaneous push/pop at q_count=3, then wrap over 20 commands
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 23'h40 + 23'(i), 16'h1000 + 16'(i) * 16'h0111, 16'h0, 1'b0);
        end
        @(negedge clk);
        check("t6_pre_q_count", {28'd0, q_count}, 32'd3);
        stall = 1'b0;
        drive_cmd(1'b1, 23'h43, 16'h1000 + 16'd3 * 16'h0111, 16'h0, 1'b0);
        @(negedge clk);
        check("t6_pushpop_q_count", {28'd0, q_count}, 32'd3);
        for (int i = 4; i < 20; i++) begin
            if (i < 10) send(1'b1, 23'h40 + 23'(i), 16'h1000 + 16'(i) * 16'h0111, 16'h0, 1'b0);
            else        send(1'b0, 23'h40 + 23'(i - 10), 16'h0, 16'h1000 + 16'(i - 10) * 16'h0111, 1'b0);
        end
        drain("t6");
        check("final_q_count", {28'd0, q_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
